// File: rtl/pwm_demodulator_if.sv
// Port bundle for the PWM demodulator: control and PWM stream in, recovered samples and status out.
// The demodulator drives the slave side; the block feeding it and reading samples uses master.
interface pwm_demodulator_if #(
  parameter int WIDTH = 11
);
  logic             en;
  logic             pwm_in;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output en,
    output pwm_in,
    input  sample_out,
    input  sample_valid,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  en,
    input  pwm_in,
    output sample_out,
    output sample_valid,
    output locked,
    output sync_err
  );
endinterface

// File: rtl/pwm_demodulator.sv
// Recovers one WIDTH-bit sample per 2^WIDTH-clock frame of a PWM stream by aligning to the
// period-start rising edge and counting high clocks across the frame.
module pwm_demodulator #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  pwm_demodulator_if.slave   bus
);

  typedef enum logic {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LAST_SAMPLE = '1;
  localparam logic [WIDTH-1:0] FIRST_CNT   = WIDTH'(1);
  localparam logic [WIDTH:0]   FIRST_HIGH  = (WIDTH+1)'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg;
  logic                   s;
  logic                   rise;

  state_t                 state_reg, state_next;
  logic [WIDTH-1:0]       frame_cnt_reg, frame_cnt_next;
  logic [WIDTH:0]         high_cnt_reg, high_cnt_next;
  logic [WIDTH:0]         total;
  logic [WIDTH-1:0]       sample_reg, sample_next;
  logic                   valid_reg, valid_next;
  logic                   locked_reg, locked_next;
  logic                   err_reg, err_next;

  // The synchronizer keeps running while disabled so edge detection is correct on re-enable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pwm_in};
      s_d_reg  <= s;
    end
  end

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= HUNT;
      frame_cnt_reg <= '0;
      high_cnt_reg  <= '0;
      sample_reg    <= '0;
      valid_reg     <= 1'b0;
      locked_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      high_cnt_reg  <= high_cnt_next;
      sample_reg    <= sample_next;
      valid_reg     <= valid_next;
      locked_reg    <= locked_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    high_cnt_next  = high_cnt_reg;
    sample_next    = sample_reg;
    valid_next     = 1'b0;
    locked_next    = locked_reg;
    err_next       = 1'b0;
    total          = high_cnt_reg + {{WIDTH{1'b0}}, s};

    if (!bus.en) begin
      state_next     = HUNT;
      frame_cnt_next = '0;
      high_cnt_next  = '0;
      locked_next    = 1'b0;
    end else begin
      case (state_reg)
        HUNT: begin
          frame_cnt_next = '0;
          high_cnt_next  = '0;
          // The rise cycle itself is sample 0 and is high.
          if (rise) begin
            state_next     = MEASURE;
            frame_cnt_next = FIRST_CNT;
            high_cnt_next  = FIRST_HIGH;
          end
        end
        MEASURE: begin
          if (rise && (frame_cnt_reg != '0)) begin
            err_next       = 1'b1;
            locked_next    = 1'b0;
            frame_cnt_next = FIRST_CNT;
            high_cnt_next  = FIRST_HIGH;
          end else if (frame_cnt_reg == LAST_SAMPLE) begin
            // Only a stuck-high frame reaches 2^WIDTH; clamp it to full scale.
            sample_next    = total[WIDTH] ? LAST_SAMPLE : total[WIDTH-1:0];
            valid_next     = 1'b1;
            locked_next    = 1'b1;
            frame_cnt_next = '0;
            high_cnt_next  = '0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
            high_cnt_next  = total;
          end
        end
        default: begin
          state_next     = HUNT;
          frame_cnt_next = '0;
          high_cnt_next  = '0;
        end
      endcase
    end
  end

  assign bus.sample_out   = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.locked       = locked_reg;
  assign bus.sync_err     = err_reg;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Bench for pwm_demodulator: a WIDTH=11 and a WIDTH=4 instance share one PWM source model; the
// selected instance is checked against a frame-window reference model, vector tables and timed sequences.
module tb_pwm_demodulator;

  localparam int SS = 2;

  typedef struct {
    int mode;        // 0 = PWM at value, 1 = stuck high, 2 = stuck low
    int value;
    int exp_sample;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic pwm = 1'b0;

  pwm_demodulator_if #(.WIDTH(11)) if11 ();
  pwm_demodulator_if #(.WIDTH(4))  if4 ();

  assign if11.en     = en;
  assign if11.pwm_in = pwm;
  assign if4.en      = en;
  assign if4.pwm_in  = pwm;

  pwm_demodulator #(.WIDTH(11), .SYNC_STAGES(SS)) dut11 (.clk(clk), .rstn(rstn), .bus(if11));
  pwm_demodulator #(.WIDTH(4),  .SYNC_STAGES(SS)) dut4  (.clk(clk), .rstn(rstn), .bus(if4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int sel = 0;
  int n_cur = 2048;

  // PWM source
  int src_t = 0;
  int src_mode = 0;
  int src_val = 0;

  // Observed outputs of the selected instance
  logic act_valid, act_err, act_locked;
  int   act_sample;
  int   got_q[$];
  int   err_cnt = 0;

  // Reference model: a frame is the window of 2^WIDTH synchronized samples starting at an aligning rise
  logic m_sync [0:SS];
  bit   m_frame[$];
  bit   m_hunt = 1'b1;
  bit   m_locked = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_err = 1'b0;
  int   m_sample = 0;

  vec_t tbl[$];

  function automatic void check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic gen_bit();
    case (src_mode)
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ((src_t % n_cur) < src_val) ? 1'b1 : 1'b0;
    endcase
  endfunction

  task automatic model_step();
    int sum;
    logic s, rise;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rstn) begin
      for (int k = 0; k <= SS; k++) m_sync[k] = 1'b0;
      m_hunt = 1'b1;
      m_frame.delete();
      m_locked = 1'b0;
      m_sample = 0;
    end else begin
      s    = m_sync[SS-1];
      rise = s & ~m_sync[SS];
      if (!en) begin
        m_hunt = 1'b1;
        m_frame.delete();
        m_locked = 1'b0;
      end else if (m_hunt) begin
        if (rise) begin
          m_hunt = 1'b0;
          m_frame.push_back(1'b1);
        end
      end else if (rise && m_frame.size() != 0) begin
        m_err = 1'b1;
        m_locked = 1'b0;
        m_frame.delete();
        m_frame.push_back(1'b1);
      end else begin
        m_frame.push_back(s);
        if (m_frame.size() == n_cur) begin
          sum = 0;
          foreach (m_frame[k]) sum += int'(m_frame[k]);
          m_sample = (sum > n_cur - 1) ? n_cur - 1 : sum;
          m_valid  = 1'b1;
          m_locked = 1'b1;
          m_frame.delete();
        end
      end
      for (int k = SS; k >= 1; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = pwm;
    end
  endtask

  task automatic tick();
    int act_pack, exp_pack;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    act_valid  = (sel != 0) ? if4.sample_valid : if11.sample_valid;
    act_err    = (sel != 0) ? if4.sync_err     : if11.sync_err;
    act_locked = (sel != 0) ? if4.locked       : if11.locked;
    act_sample = (sel != 0) ? int'(if4.sample_out) : int'(if11.sample_out);
    if (act_valid) got_q.push_back(act_sample);
    if (act_err) err_cnt++;
    if (m_valid || m_err || act_valid || act_err || (m_locked != act_locked)) begin
      act_pack = (int'(act_valid) << 14) | (int'(act_err) << 13) | (int'(act_locked) << 12) | act_sample;
      exp_pack = (int'(m_valid) << 14) | (int'(m_err) << 13) | (int'(m_locked) << 12) | m_sample;
      check($sformatf("model@cyc%0d", cyc), act_pack, exp_pack);
    end
    src_t++;
    pwm = gen_bit();
  endtask

  task automatic run_to_boundary();
    while ((src_t % n_cur) != 0) tick();
  endtask

  task automatic expect_valid(input int bound, input int j_exp, input int v, input string nm);
    int j;
    bit seen;
    j = 0;
    seen = 1'b0;
    while (!seen && j < bound) begin
      tick();
      j++;
      seen = act_valid;
    end
    check({nm, "_seen"}, int'(seen), 1);
    if (j_exp >= 0) check({nm, "_latency"}, j, j_exp);
    check({nm, "_sample"}, act_sample, v);
    check({nm, "_locked"}, int'(act_locked), 1);
  endtask

  // Each frame's sample appears early in the following frame, so vector i is checked after frame i+1.
  task automatic run_table();
    int k;
    run_to_boundary();
    for (int i = 0; i <= tbl.size(); i++) begin
      k = (i < tbl.size()) ? i : tbl.size() - 1;
      src_mode = tbl[k].mode;
      src_val  = tbl[k].value;
      pwm = gen_bit();
      got_q.delete();
      repeat (n_cur) tick();
      if (i > 0) begin
        check($sformatf("w%0d_vec%0d_count", n_cur, i-1), got_q.size(), 1);
        check($sformatf("w%0d_vec%0d_sample", n_cur, i-1),
              (got_q.size() > 0) ? got_q[0] : -1, tbl[i-1].exp_sample);
        check($sformatf("w%0d_vec%0d_locked", n_cur, i-1), int'(act_locked), 1);
      end
    end
  endtask

  task automatic run_phase(input int n, input int s_sel);
    int v1, pos, d, j, p, r;
    sel   = s_sel;
    n_cur = n;
    v1    = (n * 1000) / 2048;
    pos   = v1 + n / 8;
    d     = (n == 2048) ? 37 : 3;

    // Reset and idle source
    rstn = 1'b0; en = 1'b1; src_mode = 0; src_val = 0; src_t = 0; pwm = gen_bit();
    repeat (3) tick();
    check("rst_sample", act_sample, 0);
    check("rst_valid", int'(act_valid), 0);
    check("rst_locked", int'(act_locked), 0);
    check("rst_sync_err", int'(act_err), 0);
    rstn = 1'b1;
    got_q.delete();
    repeat (50) tick();
    check("idle_no_valid", got_q.size(), 0);
    check("idle_locked", int'(act_locked), 0);

    // Steady source: first sample one frame after the rise reaches the synchronizer output
    src_t = 0; src_val = v1; pwm = gen_bit(); err_cnt = 0;
    expect_valid(n + SS + 8, n + SS, v1, "first");
    repeat (2) expect_valid(n + 8, n, v1, "steady");
    check("steady_sync_err", err_cnt, 0);

    // Vector table: sweep, saturation, stuck low, random values
    tbl.delete();
    if (n == 2048) begin
      tbl.push_back('{0, 1000, 1000});
      tbl.push_back('{0, 1, 1});
      tbl.push_back('{0, 2, 2});
      tbl.push_back('{0, 1023, 1023});
      tbl.push_back('{0, 2046, 2046});
      tbl.push_back('{0, 2047, 2047});
      tbl.push_back('{0, 500, 500});
    end else begin
      for (int v = 0; v < n; v++) tbl.push_back('{0, v, v});
    end
    tbl.push_back('{1, 0, n - 1});
    tbl.push_back('{1, 0, n - 1});
    tbl.push_back('{2, 0, 0});
    tbl.push_back('{2, 0, 0});
    for (int q = 0; q < 3; q++) begin
      r = int'($urandom_range(n - 1, 1));
      tbl.push_back('{0, r, r});
    end
    tbl.push_back('{0, v1, v1});
    err_cnt = 0;
    run_table();
    check("table_sync_err", err_cnt, 0);

    // Phase jump: one sync_err, lock dropped, broken frame discarded, next frame correct
    run_to_boundary();
    repeat (pos) tick();
    err_cnt = 0;
    got_q.delete();
    src_t += d;
    pwm = gen_bit();
    j = 0;
    while (err_cnt == 0 && j < n + SS + 8) begin
      tick();
      j++;
    end
    check("shift_err_time", j, n - pos - d + 1 + SS);
    check("shift_unlocked", int'(act_locked), 0);
    expect_valid(n + 8, n - 1, v1, "realign");
    check("shift_err_pulses", err_cnt, 1);
    check("shift_valid_count", got_q.size(), 1);

    // Enable dropped for 10 clocks mid-frame
    run_to_boundary();
    repeat (pos) tick();
    got_q.delete();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    check("en_hold_sample", act_sample, v1);
    check("en_unlocked", int'(act_locked), 0);
    check("en_no_valid", got_q.size(), 0);
    expect_valid(3 * n + 8, -1, v1, "relock");

    // One-cycle reset mid-frame
    run_to_boundary();
    repeat (pos) tick();
    rstn = 1'b0;
    tick();
    check("midrst_sample", act_sample, 0);
    check("midrst_valid", int'(act_valid), 0);
    check("midrst_locked", int'(act_locked), 0);
    check("midrst_sync_err", int'(act_err), 0);
    rstn = 1'b1;
    p = src_t % n;
    expect_valid(2 * n + 8, 2 * n - p + SS, v1, "post_reset");
  endtask

  initial begin
    for (int k = 0; k <= SS; k++) m_sync[k] = 1'b0;
    run_phase(2048, 0);
    run_phase(16, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
